instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning fetch queue depth and request credit limit (legal range 1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-007 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1, response valid; responses return in order, latency >= 1 cycle.
REQ-009 SHALL have port imem_rsp_data, input, 32, fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1, taken branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc, input, 32, redirect target.
REQ-012 SHALL have port inst_valid, output, 1, instruction available to decode/immediate generation.
REQ-013 SHALL have port inst_ready, input, 1, decode consumes instruction.
REQ-014 SHALL have port inst, output, 32, instruction word for decode.
REQ-015 SHALL have port inst_pc, output, 32, address of inst.
REQ-016 SHALL have port fetch_exc, output, 1, misaligned-redirect flag (see Configuration).

Function
REQ-017 SHALL hold fetch PC, a FIFO of {inst, pc} with MAX_OUTSTANDING entries, an in-flight count, and a stale-response count.
REQ-018 SHALL assert imem_req_valid only when in_flight + fifo_count < MAX_OUTSTANDING, redirect_valid is low, and fetch is not halted; imem_addr = fetch PC.
REQ-019 SHALL, on imem_req_valid && imem_req_ready, increment in_flight and advance fetch PC by 4 (wraps 32'hFFFF_FFFC -> 0).
REQ-020 SHALL, on imem_rsp_valid with stale count zero, push {imem_rsp_data, pc} into the FIFO and decrement in_flight; pc is tracked per request in order.
REQ-021 SHALL, on imem_rsp_valid with stale count nonzero, drop the response and decrement the stale count.
REQ-022 SHALL present FIFO head combinationally: inst_valid = FIFO non-empty; pop on inst_valid && inst_ready; push and pop in the same cycle are both honoured.
REQ-023 SHALL give one-cycle latency from response to inst_valid (registered FIFO write, visible next cycle).
REQ-024 SHALL, on redirect_valid, flush the FIFO, set fetch PC = {redirect_pc[31:2], 2'b00}, move all in-flight requests (minus any response dropped that cycle) to the stale count, zero in_flight; a response arriving in the redirect cycle is discarded.
REQ-025 SHALL ignore inst_ready in a redirect cycle (flush wins over pop); inst_valid is low the cycle after redirect.
REQ-026 SHALL never let in_flight + stale + fifo_count exceed MAX_OUTSTANDING + stale outstanding requests; no FIFO overflow is reachable under REQ-018.

Reset
REQ-027 SHALL, while rst is high, set fetch PC = RESET_PC, FIFO empty, in_flight = 0, stale = 0, fetch_exc = 0, imem_req_valid = 0, inst_valid = 0.
REQ-028 SHALL treat reset mid-operation as discarding all state; responses to pre-reset requests are the memory's responsibility to suppress.
REQ-029 SHALL issue the first request at RESET_PC the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with IFETCH_MISALIGN_CHK_EN defined, on redirect with redirect_pc[1:0] != 0, set fetch_exc = 1 and halt requests until the next aligned redirect or reset, which clears fetch_exc.
REQ-031 SHALL, without IFETCH_MISALIGN_CHK_EN, tie fetch_exc to 0 and silently clear redirect_pc[1:0].

Verification
REQ-032 SHALL cover reset then ready=1, 1-cycle memory: imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches, inst_valid from cycle 2.
REQ-033 SHALL cover inst_ready = 0 for 5 cycles: exactly MAX_OUTSTANDING (2) requests issued, then imem_req_valid low until a pop.
REQ-034 SHALL cover redirect to 0x100 with 2 requests in flight: both late responses dropped, next inst_pc = 0x100.
REQ-035 SHALL cover simultaneous redirect, response and inst_ready: FIFO empty next cycle, response discarded, no pop counted.
REQ-036 SHALL cover PC wrap from 0xFFFF_FFFC: next imem_addr = 0x0000_0000.
REQ-037 SHALL cover redirect to 0x102 with IFETCH_MISALIGN_CHK_EN: fetch_exc = 1, no requests; without macro: fetch from 0x100.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - in-order instruction fetch unit with redirect flush and stale-response dropping
// Optional misaligned-redirect trap: define IFETCH_MISALIGN_CHK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_exc
);

    localparam logic [2:0] MAX_C   = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fifo_inst_q [4];
    logic [31:0] fifo_pc_q   [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  in_flight_q, in_flight_d;
    logic [7:0]  stale_q, stale_d;
    logic        halt_q, halt_d;

    logic        req_fire, rsp_live, push, pop;
    logic [31:0] rsp_pc, redirect_target;

    // Live in-flight requests are consecutive since the last redirect, so the
    // oldest one's address is recovered from the fetch PC.
    assign rsp_pc          = pc_q - {27'b0, in_flight_q, 2'b00};
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_addr      = pc_q;
    assign imem_req_valid = !rst && !halt_q && !redirect_valid && ((in_flight_q + count_q) < MAX_C);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (stale_q == 8'd0);
    assign push           = rsp_live && !redirect_valid;
    assign inst_valid     = !rst && (count_q != 3'd0);
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    assign inst           = fifo_inst_q[rd_ptr_q];
    assign inst_pc        = fifo_pc_q[rd_ptr_q];
    assign fetch_exc      = halt_q;

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_flight_d = in_flight_q;
        stale_d     = stale_q;
        halt_d      = halt_q;
        if (redirect_valid) begin
            pc_d        = redirect_target;
            wr_ptr_d    = 2'd0;
            rd_ptr_d    = 2'd0;
            count_d     = 3'd0;
            in_flight_d = 3'd0;
            stale_d     = stale_q + {5'b0, in_flight_q} - {7'b0, imem_rsp_valid};
`ifdef IFETCH_MISALIGN_CHK_EN
            halt_d      = (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            in_flight_d = in_flight_q + {2'b0, req_fire} - {2'b0, rsp_live};
            if (imem_rsp_valid && !rsp_live) stale_d = stale_q - 8'd1;
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? 2'd0 : wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 2'd0 : rd_ptr_q + 2'd1;
            count_d = count_q + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            in_flight_q <= 3'd0;
            stale_q     <= 8'd0;
            halt_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            stale_q     <= stale_d;
            halt_q      <= halt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch with an in-order 1-cycle memory model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        fetch_exc;

    int          n_vec = 0;
    int          n_err = 0;
    int          nreq  = 0;
    logic        mem_en;
    logic [31:0] pend [$];

    instr_fetch #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .fetch_exc(fetch_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory answers each accepted request in order, one cycle later at the earliest.
    task automatic tick();
        logic        f_req, f_rsp;
        logic [31:0] a;
        f_req = imem_req_valid && imem_req_ready;
        f_rsp = imem_rsp_valid;
        a     = imem_addr;
        @(posedge clk);
        #1;
        if (f_rsp && pend.size() > 0) void'(pend.pop_front());
        if (f_req) begin
            pend.push_back(a);
            nreq++;
        end
        imem_rsp_valid = mem_en && (pend.size() > 0);
        imem_rsp_data  = (pend.size() > 0) ? ~pend[0] : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        pend.delete();
        imem_rsp_valid = 1'b0;
        tick();
        rst  = 1'b0;
        nreq = 0;
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // reset state
        tick(); tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_fetch_exc", {31'b0, fetch_exc}, 32'd0);

        // streaming with 1-cycle memory
        do_reset();
        chk("s_c0_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s_c0_addr", imem_addr, 32'h0);
        tick();
        chk("s_c1_addr", imem_addr, 32'h4);
        chk("s_c1_inst_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("s_c2_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("s_c2_inst_pc", inst_pc, 32'h0);
        chk("s_c2_inst", inst, 32'hFFFF_FFFF);
        chk("s_c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        chk("s_c3_addr", imem_addr, 32'h8);
        chk("s_c3_inst_pc", inst_pc, 32'h4);

        // decode stalled: credit limit holds at two requests
        do_reset();
        inst_ready = 1'b0;
        repeat (5) tick();
        chk("stall_nreq", 32'(nreq), 32'd2);
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_inst_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        #1;
        tick();
        chk("stall_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("stall_resume_addr", imem_addr, 32'h8);
        chk("stall_resume_pc", inst_pc, 32'h4);

        // redirect with two requests in flight
        do_reset();
        mem_en = 1'b0;
        tick(); tick();
        chk("rd_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h100; mem_en = 1'b1;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_new_addr", imem_addr, 32'h100);
        chk("rd_A_inst_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("rd_B_inst_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("rd_C_inst_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("rd_D_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("rd_D_inst_pc", inst_pc, 32'h100);
        chk("rd_D_inst", inst, 32'hFFFF_FEFF);

        // redirect, response and inst_ready in the same cycle
        do_reset();
        inst_ready = 1'b0;
        tick(); tick();
        chk("sim_pre_inst_valid", {31'b0, inst_valid}, 32'd1);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("sim_flush_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("sim_addr", imem_addr, 32'h200);
        tick(); tick();
        chk("sim_next_valid", {31'b0, inst_valid}, 32'd1);
        chk("sim_next_pc", inst_pc, 32'h200);

        // PC wrap
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        chk("wrap_valid1", {31'b0, imem_req_valid}, 32'd1);
        tick();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

        // misaligned redirect
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        nreq = 0;
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("mis_exc", {31'b0, fetch_exc}, 32'd1);
        chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick(); tick();
        chk("mis_nreq", 32'(nreq), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("mis_clear_exc", {31'b0, fetch_exc}, 32'd0);
        chk("mis_clear_addr", imem_addr, 32'h300);
`else
        chk("mis_exc", {31'b0, fetch_exc}, 32'd0);
        chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("mis_addr", imem_addr, 32'h100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
